// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//   Runtime-programmable integer clock divider. It supports even and odd
//   ratios, a loadable divisor that takes effect only at period boundaries,
//   and a run enable that is also honoured only at period boundaries. Every
//   high phase and every low phase is therefore either complete or absent,
//   never truncated.
//
//   A single-cycle tick in the clk domain marks the start of each period.
//   Downstream logic should use tick as a clock-enable rather than routing
//   clk_out as a clock.
//
// Optional feature (macro CLK_DIV_ODD50_EN):
//   defined   : odd ratios produce exactly 50% duty. This uses one extra flop
//               clocked on the falling edge of clk.
//   undefined : clk_out is fully posedge-registered. Odd N is high for
//               (N+1)/2 cycles and low for (N-1)/2 cycles.
//
// Parameters:
//   CNT_W       width of the divisor and the counter (legal N: 2..2^CNT_W-1)
//   DIV_DEFAULT ratio in force after reset
//
// Ports:
//   clk      source clock
//   rst_n    asynchronous active-low reset
//   en       run request, acted on at period boundaries (or at once if stopped)
//   div_val  requested ratio N
//   div_load one-cycle strobe that captures div_val
//   clk_out  divided clock, period div_cur clk cycles
//   tick     one-cycle pulse in the cycle where a period starts (cnt == 0)
//   div_cur  ratio currently in force
//   running  high while periods are being produced
//   load_err one-cycle pulse after a rejected load (div_val < 2)
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int CNT_W       = 10,
    parameter int DIV_DEFAULT = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             running,
    output logic             load_err
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // State registers
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] div_q,  div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             run_q,  run_d;
    logic             qp_q,   qp_d;
    logic             tick_q, tick_d;
    logic             err_q,  err_d;

    // Combinational helpers
    logic             load_ok;
    logic             load_bad;
    logic             last_cyc;
    logic             boundary;
    logic             pend_hit;
    logic [CNT_W-1:0] pend_val;
    logic [CNT_W-1:0] half_d;

    always_comb begin
        load_ok  = div_load && (div_val >= TWO);
        load_bad = div_load && (div_val <  TWO);

        // A valid load in the same cycle takes priority over the stored
        // pending value, so a load in the boundary cycle applies immediately.
        pend_hit = load_ok || pend_vld_q;
        pend_val = load_ok ? div_val : pend_q;

        last_cyc = (cnt_q == (div_q - ONE));

        // While stopped, every cycle behaves as a boundary. That lets a
        // pending ratio and a start request both take effect on the next edge.
        boundary = !run_q || last_cyc;

        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        run_d      = run_q;
        err_d      = load_bad;

        if (load_ok) begin
            pend_d     = div_val;
            pend_vld_d = 1'b1;
        end

        if (boundary) begin
            if (pend_hit) begin
                div_d      = pend_val;
                pend_vld_d = 1'b0;
            end
            run_d = en;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        // Outputs are computed from the next state, so clk_out and tick
        // become valid at the same edge that moves cnt to its new value.
        // Even N: high while cnt < N/2.
        // Odd N:  high while cnt <= (N-1)/2, i.e. for (N+1)/2 cycles.
        half_d = div_d >> 1;
        if (div_d[0])
            qp_d = run_d && (cnt_d <= half_d);
        else
            qp_d = run_d && (cnt_d <  half_d);

        tick_d = run_d && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= DIV_RST;
            pend_q     <= DIV_RST;
            pend_vld_q <= 1'b0;
            run_q      <= 1'b0;
            qp_q       <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            run_q      <= run_d;
            qp_q       <= qp_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

`ifdef CLK_DIV_ODD50_EN
    // For odd N, qn_q is qp_q delayed by half a clk period. ANDing the two
    // starts the high phase half a cycle late, leaving N/2 cycles high.
    // div_q only changes together with the cnt wrap, while qp_q is rising
    // and qn_q is still low from the previous period's low phase. So
    // switching the select never exposes a stale high.
    logic qn_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            qn_q <= 1'b0;
        else
            qn_q <= qp_q;
    end

    assign clk_out = div_q[0] ? (qp_q & qn_q) : qp_q;
`else
    assign clk_out = qp_q;
`endif

    assign tick     = tick_q;
    assign div_cur  = div_q;
    assign running  = run_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] div_cur;
    logic             running;
    logic             load_err;

    clk_div_prog #(.CNT_W(CNT_W), .DIV_DEFAULT(20)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_val (div_val),
        .div_load(div_load),
        .clk_out (clk_out),
        .tick    (tick),
        .div_cur (div_cur),
        .running (running),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Expected period shape, measured in half-clk samples.
    typedef struct {
        int per;
        int hi;
    } per_t;

    per_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   sb_on = 1'b0;

    // High time of an odd period, in half-cycle samples.
`ifdef CLK_DIV_ODD50_EN
    function automatic int hi_odd(input int n);
        return n;
    endfunction
`else
    function automatic int hi_odd(input int n);
        return n + 1;
    endfunction
`endif

    // Monitor: samples clk_out on both clk edges and measures each completed
    // period from one rise to the next. When enabled, it pops the next
    // expected period from the scoreboard and compares.
    bit   m_prev = 1'b0;
    bit   m_have = 1'b0;
    int   m_pc   = 0;
    int   m_hc   = 0;
    per_t m_e;

    initial begin
        forever begin
            @(clk);
            #2;
            if (!rst_n || !running) begin
                m_have = 1'b0;
                m_prev = clk_out;
                m_pc   = 0;
                m_hc   = 0;
            end else begin
                if (clk_out && !m_prev) begin
                    if (m_have && sb_on && exp_q.size() > 0) begin
                        m_e   = exp_q.pop_front();
                        total = total + 1;
                        if (m_pc !== m_e.per || m_hc !== m_e.hi) begin
                            bad = bad + 1;
                            $display("FAIL period_shape: got per=%0d hi=%0d, want per=%0d hi=%0d (half-cycles) t=%0t",
                                     m_pc, m_hc, m_e.per, m_e.hi, $time);
                        end
                    end
                    m_have = 1'b1;
                    m_pc   = 0;
                    m_hc   = 0;
                end
                m_pc = m_pc + 1;
                if (clk_out) m_hc = m_hc + 1;
                m_prev = clk_out;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int per, input int hi, input int times);
        per_t e;
        e.per = per;
        e.hi  = hi;
        for (int i = 0; i < times; i++) exp_q.push_back(e);
    endtask

    // Advance until tick is seen (cnt == 0 after the edge).
    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!tick && k < 200);
        if (!tick) begin
            total++;
            bad++;
            $display("FAIL wait_tick: tick=%0b after %0d cycles, want 1", tick, k);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    endtask

    task automatic wait_div(input int n);
        for (int i = 0; i < 100 && div_cur != n[CNT_W-1:0]; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
        repeat (3) step();
        total += 5;
        if (clk_out !== 1'b0) begin bad++; $display("FAIL rst_clk_out: got %0b want 0", clk_out); end
        if (tick !== 1'b0)    begin bad++; $display("FAIL rst_tick: got %0b want 0", tick); end
        if (running !== 1'b0) begin bad++; $display("FAIL rst_running: got %0b want 0", running); end
        if (load_err !== 1'b0) begin bad++; $display("FAIL rst_load_err: got %0b want 0", load_err); end
        if (div_cur !== 10'd20) begin bad++; $display("FAIL rst_div_cur: got %0d want 20", div_cur); end
        en = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        total += 3;
        if (clk_out !== 1'b1) begin bad++; $display("FAIL start_clk_out: got %0b want 1", clk_out); end
        if (tick !== 1'b1)    begin bad++; $display("FAIL start_tick: got %0b want 1", tick); end
        if (running !== 1'b1) begin bad++; $display("FAIL start_running: got %0b want 1", running); end
    endtask

    task automatic test_default();
        int ticks;
        repeat (3) step();
        sb_on = 1'b1;
        push(40, 20, 3);
        ticks = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tick) ticks++;
        end
        wait_drain();
        total += 3;
        if (ticks != 3) begin bad++; $display("FAIL default_ticks: got %0d want 3", ticks); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL default_drain: %0d periods missing, want 0", exp_q.size()); end
        if (div_cur !== 10'd20) begin bad++; $display("FAIL default_div_cur: got %0d want 20", div_cur); end
        sb_on = 1'b0;
    endtask

    task automatic test_load7();
        wait_tick();
        repeat (5) step();
        sb_on = 1'b1;
        push(40, 20, 1);
        push(14, hi_odd(7), 2);
        div_val = 10'd7; div_load = 1'b1;
        step();
        div_load = 1'b0;
        total += 2;
        if (div_cur !== 10'd20) begin bad++; $display("FAIL load7_deferred: got %0d want 20", div_cur); end
        if (load_err !== 1'b0)  begin bad++; $display("FAIL load7_err: got %0b want 0", load_err); end
        wait_drain();
        total += 2;
        if (exp_q.size() != 0) begin bad++; $display("FAIL load7_drain: %0d periods missing, want 0", exp_q.size()); end
        if (div_cur !== 10'd7) begin bad++; $display("FAIL load7_div_cur: got %0d want 7", div_cur); end
        sb_on = 1'b0;
    endtask

    task automatic test_back_to_back();
        wait_tick();
        repeat (6) step();
        sb_on = 1'b1;
        push(14, hi_odd(7), 1);
        push(8, 4, 1);
        push(12, 6, 2);
        // Load strobe sampled on the wrap edge.
        div_val = 10'd4; div_load = 1'b1;
        step();
        div_load = 1'b0;
        total += 2;
        if (div_cur !== 10'd4) begin bad++; $display("FAIL b2b_boundary_apply: got %0d want 4", div_cur); end
        if (tick !== 1'b1)     begin bad++; $display("FAIL b2b_tick: got %0b want 1", tick); end
        step();
        div_val = 10'd6; div_load = 1'b1;
        step();
        div_load = 1'b0;
        total += 1;
        if (div_cur !== 10'd4) begin bad++; $display("FAIL b2b_pending: got %0d want 4", div_cur); end
        wait_drain();
        total += 2;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: %0d periods missing, want 0", exp_q.size()); end
        if (div_cur !== 10'd6) begin bad++; $display("FAIL b2b_div_cur: got %0d want 6", div_cur); end
        sb_on = 1'b0;
    endtask

    task automatic test_bad_load();
        wait_tick();
        repeat (2) step();
        sb_on = 1'b1;
        push(12, 6, 2);
        div_val = 10'd1; div_load = 1'b1;
        step();
        div_load = 1'b0;
        total += 2;
        if (load_err !== 1'b1) begin bad++; $display("FAIL bad1_err: got %0b want 1", load_err); end
        if (div_cur !== 10'd6) begin bad++; $display("FAIL bad1_div_cur: got %0d want 6", div_cur); end
        step();
        total += 1;
        if (load_err !== 1'b0) begin bad++; $display("FAIL bad1_err_clear: got %0b want 0", load_err); end
        div_val = 10'd0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        total += 1;
        if (load_err !== 1'b1) begin bad++; $display("FAIL bad0_err: got %0b want 1", load_err); end
        step();
        total += 1;
        if (load_err !== 1'b0) begin bad++; $display("FAIL bad0_err_clear: got %0b want 0", load_err); end
        wait_drain();
        total += 2;
        if (exp_q.size() != 0) begin bad++; $display("FAIL bad_drain: %0d periods missing, want 0", exp_q.size()); end
        if (div_cur !== 10'd6) begin bad++; $display("FAIL bad_div_cur: got %0d want 6", div_cur); end
        sb_on = 1'b0;
    endtask

    task automatic test_stop();
        int seen;
        div_val = 10'd10; div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_div(10);
        wait_tick();
        repeat (3) step();
        en = 1'b0;
        step();
        total += 2;
        if (clk_out !== 1'b1) begin bad++; $display("FAIL stop_cnt4_clk_out: got %0b want 1", clk_out); end
        if (running !== 1'b1) begin bad++; $display("FAIL stop_cnt4_running: got %0b want 1", running); end
        repeat (5) step();
        total += 2;
        if (running !== 1'b1) begin bad++; $display("FAIL stop_cnt9_running: got %0b want 1", running); end
        if (clk_out !== 1'b0) begin bad++; $display("FAIL stop_cnt9_clk_out: got %0b want 0", clk_out); end
        step();
        total += 3;
        if (running !== 1'b0) begin bad++; $display("FAIL stop_running: got %0b want 0", running); end
        if (clk_out !== 1'b0) begin bad++; $display("FAIL stop_clk_out: got %0b want 0", clk_out); end
        if (tick !== 1'b0)    begin bad++; $display("FAIL stop_tick: got %0b want 0", tick); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clk_out || tick || running) seen++;
        end
        total += 1;
        if (seen != 0) begin bad++; $display("FAIL stop_idle: active cycles=%0d want 0", seen); end
        en = 1'b1;
        step();
        total += 3;
        if (clk_out !== 1'b1) begin bad++; $display("FAIL restart_clk_out: got %0b want 1", clk_out); end
        if (tick !== 1'b1)    begin bad++; $display("FAIL restart_tick: got %0b want 1", tick); end
        if (running !== 1'b1) begin bad++; $display("FAIL restart_running: got %0b want 1", running); end
        repeat (3) step();
        sb_on = 1'b1;
        push(20, 10, 2);
        wait_drain();
        total += 1;
        if (exp_q.size() != 0) begin bad++; $display("FAIL restart_drain: %0d periods missing, want 0", exp_q.size()); end
        sb_on = 1'b0;
    endtask

    task automatic test_reset_mid();
        div_val = 10'd14; div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_div(14);
        wait_tick();
        repeat (5) step();
        total += 1;
        if (clk_out !== 1'b1) begin bad++; $display("FAIL rmid_pre_clk_out: got %0b want 1", clk_out); end
        #2;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (clk_out !== 1'b0)   begin bad++; $display("FAIL rmid_async_clk_out: got %0b want 0", clk_out); end
        if (running !== 1'b0)   begin bad++; $display("FAIL rmid_running: got %0b want 0", running); end
        if (tick !== 1'b0)      begin bad++; $display("FAIL rmid_tick: got %0b want 0", tick); end
        if (div_cur !== 10'd20) begin bad++; $display("FAIL rmid_div_cur: got %0d want 20", div_cur); end
        step();
        rst_n = 1'b1;
        step();
        total += 3;
        if (tick !== 1'b1)      begin bad++; $display("FAIL rmid_restart_tick: got %0b want 1", tick); end
        if (clk_out !== 1'b1)   begin bad++; $display("FAIL rmid_restart_clk_out: got %0b want 1", clk_out); end
        if (div_cur !== 10'd20) begin bad++; $display("FAIL rmid_restart_div: got %0d want 20", div_cur); end
        repeat (3) step();
        sb_on = 1'b1;
        push(40, 20, 1);
        wait_drain();
        total += 1;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_drain: %0d periods missing, want 0", exp_q.size()); end
        sb_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_load7();
        test_back_to_back();
        test_bad_load();
        test_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider, the parametrised successor to the fixed even-ratio divider. It supports both even and odd ratios, a loadable divisor, glitch-free ratio changes at period boundaries, and a gated enable. It also emits a single-cycle tick in the clk domain, for use as a clock-enable instead of routing clk_out as a clock. It sits between the system clock and low-rate peripheral timing such as UART baud, PWM bases and LED scan.

Parameters:
CNT_W, 10, width of the divisor and the internal counter; legal ratios are 2 .. 2^CNT_W-1.
DIV_DEFAULT, 20, ratio in force after reset; must satisfy 2 <= DIV_DEFAULT <= 2^CNT_W-1.

Ports:
clk  input  1  source clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  run request; sampled only at period boundaries (see Behaviour)
div_val  input  CNT_W  requested ratio N
div_load  input  1  one-cycle strobe; captures div_val
clk_out  output  1  divided clock, period N clk cycles
tick  output  1  one-cycle pulse in the clk cycle where clk_out rises
div_cur  output  CNT_W  ratio currently in force
running  output  1  high while the divider is producing periods
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset values: cnt=0, div_cur=DIV_DEFAULT, pending register empty, clk_out=0, tick=0, running=0, load_err=0.
- Counter: cnt counts 0..div_cur-1 on posedge clk while running, then wraps to 0. The wrap cycle is the period boundary.
- Even N: clk_out is high for cnt 0..N/2-1 and low for cnt N/2..N-1, giving exactly 50% duty.
- Odd N: see Optional Feature.
- tick: registered, high exactly one clk cycle per period, in the cycle cnt==0. Not asserted while stopped.
- Start:
  - While stopped, en=1 sampled at posedge sets running=1 and cnt=0 at that edge.
  - clk_out and tick go high at that same edge, so latency is 1 clk from en.
  - After reset release with en=1, the first clk_out rise is on the first posedge.
- Stop:
  - en=0 is acted on only at a period boundary.
  - The current period completes, then running=0, cnt is held at 0 and clk_out is held low.
  - No truncated high or low phase is allowed.
- Ratio load:
  - div_load=1 with 2 <= div_val <= 2^CNT_W-1 writes the pending register; a later load overwrites an unapplied one.
  - The pending value becomes div_cur at the next period boundary.
  - A load in the boundary cycle itself applies at that boundary, so the following period uses the new N.
  - While stopped, the pending value applies immediately at the next posedge.
- Invalid load: div_val < 2 is ignored; the pending register and div_cur are unchanged, and load_err pulses for 1 cycle on the next edge.
- Width rules: the half-period compare uses N>>1 computed in CNT_W bits. No overflow is possible, because cnt < div_cur.
- Reset mid-period: clk_out drops to 0 asynchronously, and all state returns to its reset values.

Optional Feature:
Macro CLK_DIV_ODD50_EN.
- Defined:
  - Odd N gives 50% duty. A posedge-generated phase q_p is high for cnt 0..(N-1)/2, i.e. (N+1)/2 cycles.
  - A negedge flop captures q_p as q_n, and clk_out = q_p & q_n for odd N, giving N/2 cycles high.
  - Even N uses q_p directly.
  - q_n resets to 0 asynchronously.
- Undefined:
  - No negedge logic is built, and clk_out is fully posedge-registered.
  - Odd N is high for (N+1)/2 cycles and low for (N-1)/2 cycles.

Test Plan:
- Reset, en=1, DIV_DEFAULT=20 -> clk_out period 20 clk, high 10 / low 10; tick one pulse every 20 cycles; div_cur=20.
- Load N=7 mid-period -> current 20-cycle period completes, then period 7. With CLK_DIV_ODD50_EN: high 3.5 clk. Without: high 4 / low 3.
- Load N=4 in the boundary cycle, then N=6 before the next boundary -> one period of 4, then periods of 6.
- Load div_val=1 and div_val=0 -> load_err pulses once per attempt; div_cur and period unchanged.
- Drop en at cnt=3 with N=10 -> period completes at cnt=9, then clk_out stays 0, running=0, no tick. Re-raise en -> clk_out and tick high 1 clk later.
- Assert rst_n low at cnt=5 while clk_out is high -> clk_out=0 immediately; after release, div_cur=20 and cnt restarts from 0.
